fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly downstream of the PC register. It consumes the current PC and issues one instruction-memory request at a time. Fetched {pc, instr} pairs are buffered in a small queue toward decode. The block drives the PC register's write enable and next-PC value, so it alone decides when the PC advances (sequential +4 or branch/jump redirect).

---
 rtl/cpu_fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 63 ++++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Types and constants shared by the fetch stage, the PC register and the bench.
package cpu_fetch_pkg;

    localparam logic [31:0] RESET_PC     = 32'h0040_0000;
    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of {pc, instr} entries between fetch and decode.
module fetch_queue
    import cpu_fetch_pkg::*;
#(
    parameter  int unsigned QDEPTH = 2,
    localparam int unsigned PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
    localparam int unsigned CNT_W  = $clog2(QDEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  fetch_entry_t     i_entry,
    input  logic             i_pop,
    output fetch_entry_t     o_head,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    fetch_entry_t     r_mem [QDEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Flush wins over both push and pop; a push into a full queue is only
    // accepted when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;
    assign w_do_push = i_push && !i_flush &&
                       ((r_count != CNT_W'(QDEPTH)) || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, owns PC advance and
// redirect, and buffers fetched {pc, instr} pairs toward decode.
module fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned DATA_W = FETCH_DATA_W,
    parameter int unsigned QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_wena,
    output logic [ADDR_W-1:0] npc_out,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc4
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic              r_req;
    logic              w_req_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              w_issue;
    logic              w_ack_live;
    logic              w_pop;
    logic              w_head_valid;
    logic [CNT_W-1:0]  w_count;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            if (w_issue) begin
                r_addr <= pc_in;
            end
        end
    end

    // Re-issue after an ack always goes through IDLE so the next address is
    // taken from the PC register after it has absorbed the +4 update.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_issue     = 1'b0;
        w_ack_live  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!redirect_valid && (w_count < CNT_W'(QDEPTH))) begin
                    w_issue     = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                    w_ack_live  = !redirect_valid;
                end else if (redirect_valid) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.pc    = r_addr;
        w_push_entry.instr = imem_rdata;
    end

    assign w_pop = w_head_valid && id_ready;

    fetch_queue #(
        .QDEPTH(QDEPTH)
    ) u_queue (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_flush (redirect_valid),
        .i_push  (w_ack_live),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_head_valid),
        .o_count (w_count)
    );

    always_comb begin
        pc_wena = redirect_valid || w_ack_live;
        if (redirect_valid) begin
            npc_out = redirect_pc;
        end else if (w_ack_live) begin
            npc_out = r_addr + ADDR_W'(4);
        end else begin
            npc_out = pc_in + ADDR_W'(4);
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign id_valid  = w_head_valid;
    assign id_pc     = w_head.pc;
    assign id_instr  = w_head.instr;
    assign id_pc4    = w_head.pc + ADDR_W'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit with a stream-level reference
// model: decode must see consecutive PCs from the last reset or redirect.
module tb_fetch_unit;
    import cpu_fetch_pkg::*;

    localparam int unsigned QD = 2;

    logic        clk;
    logic        rst;
    logic [31:0] pc_reg;
    logic        pc_wena;
    logic [31:0] npc_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    int          n_pass;
    int          n_total;
    int          occ;
    int          wait_cnt;
    int          mem_delay;
    int          pops_cnt;
    int          wena_cnt;
    logic [31:0] exp_pc;
    logic [31:0] fetch_pc;
    logic [31:0] prev_addr;
    logic [31:0] s_npc;
    bit          prev_live;
    bit          stale;
    bit          rand_mem;
    bit          ready_rand;
    bit          ready_fix;
    bit          s_wena;
    bit          s_newreq;
    bit          found;

    fetch_unit #(
        .ADDR_W(32),
        .DATA_W(32),
        .QDEPTH(QD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_reg),
        .pc_wena        (pc_wena),
        .npc_out        (npc_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_reg <= RESET_PC;
        else if (pc_wena) pc_reg <= npc_out;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic reset_model();
        occ       = 0;
        exp_pc    = RESET_PC;
        fetch_pc  = RESET_PC;
        prev_live = 1'b0;
        stale     = 1'b0;
    endtask

    task automatic monitor();
        bit live_ack;
        bit pop;
        s_wena   = pc_wena;
        s_npc    = npc_out;
        s_newreq = 1'b0;
        if (!rst) begin
            check("rst_req", imem_req, 0);
            check("rst_valid", id_valid, 0);
            check("rst_wena", pc_wena, redirect_valid);
            reset_model();
            return;
        end
        if (prev_live) begin
            check("req_hold", imem_req, 1);
            check("addr_hold", imem_addr, prev_addr);
        end else if (imem_req) begin
            s_newreq = 1'b1;
            check("req_addr", imem_addr, fetch_pc);
        end
        check("id_valid", id_valid, occ != 0);
        live_ack = imem_ack && !stale;
        check("pc_wena", pc_wena, redirect_valid || live_ack);
        if (redirect_valid) check("npc_redir", npc_out, redirect_pc);
        else if (live_ack) check("npc_seq", npc_out, fetch_pc + 32'd4);
        if (live_ack && !redirect_valid) check("slot_free", occ < QD, 1);
        pop = (occ != 0) && id_ready && !redirect_valid;
        if (pop) begin
            check("id_pc", id_pc, exp_pc);
            check("id_instr", id_instr, mem_fn(exp_pc));
            check("id_pc4", id_pc4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            pops_cnt++;
        end
        if (redirect_valid || live_ack) wena_cnt++;
        if (redirect_valid) begin
            occ      = 0;
            exp_pc   = redirect_pc;
            fetch_pc = redirect_pc;
        end else begin
            occ = occ + int'(live_ack) - int'(pop);
            if (live_ack) fetch_pc = fetch_pc + 32'd4;
        end
        stale     = imem_ack ? 1'b0 : (stale || (redirect_valid && imem_req));
        prev_live = imem_req && !imem_ack;
        prev_addr = imem_addr;
    endtask

    // One clock: drive memory/decode/redirect inputs after the edge, sample at negedge.
    task automatic step(input bit redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        imem_ack       = imem_req && (wait_cnt >= mem_delay);
        imem_rdata     = mem_fn(imem_addr);
        redirect_valid = redir;
        redirect_pc    = rpc;
        id_ready       = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
        @(negedge clk);
        monitor();
        if (imem_ack) begin
            wait_cnt = 0;
            if (rand_mem) mem_delay = int'($urandom_range(0, 3));
        end else if (imem_req) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
    endtask

    initial begin
        n_pass = 0; n_total = 0; pops_cnt = 0; wena_cnt = 0;
        wait_cnt = 0; mem_delay = 0;
        rand_mem = 1'b0; ready_rand = 1'b0; ready_fix = 1'b1;
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b1;
        reset_model();

        // Reset held for three cycles, then first request one cycle after release.
        repeat (3) step(1'b0, '0);
        rst = 1'b1;
        step(1'b0, '0);
        check("rel_req", imem_req, 1);
        check("rel_addr", imem_addr, RESET_PC);

        // Zero-wait stream: one instruction every two cycles.
        repeat (4) step(1'b0, '0);
        pops_cnt = 0; wena_cnt = 0;
        repeat (20) step(1'b0, '0);
        check("zw_pops", pops_cnt, 10);
        check("zw_wena", wena_cnt, 10);

        // Backpressure: queue fills to QDEPTH and fetch stalls.
        ready_fix = 1'b0;
        repeat (12) step(1'b0, '0);
        check("bp_occ", occ, QD);
        repeat (5) begin
            step(1'b0, '0);
            check("bp_noreq", imem_req, 0);
            check("bp_nowena", s_wena, 0);
        end
        ready_fix = 1'b1;
        repeat (10) step(1'b0, '0);

        // Redirect while an ack is 3 cycles late.
        mem_delay = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, '0);
            if (imem_req && !imem_ack && wait_cnt == 1) found = 1'b1;
        end
        check("dr_reach", found, 1);
        step(1'b1, 32'h0040_0100);
        step(1'b0, '0);
        check("dr_req_held", imem_req, 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, '0);
            if (s_newreq) found = 1'b1;
        end
        check("dr_newreq", found, 1);
        check("dr_addr", imem_addr, 32'h0040_0100);
        mem_delay = 0;
        repeat (10) step(1'b0, '0);

        // Redirect in the same cycle as an ack with an entry queued.
        step(1'b1, 32'h0040_0180);
        ready_fix = 1'b0;
        mem_delay = 2;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, '0);
            if (occ == 1 && imem_req && !imem_ack) found = 1'b1;
        end
        check("ra_reach", found, 1);
        mem_delay = 0;
        step(1'b1, 32'h0040_0200);
        check("ra_ack", imem_ack, 1);
        check("ra_wena", s_wena, 1);
        check("ra_npc", s_npc, 32'h0040_0200);
        step(1'b0, '0);
        check("ra_empty", id_valid, 0);
        ready_fix = 1'b1;
        repeat (10) step(1'b0, '0);

        // Asynchronous reset while a request is outstanding.
        mem_delay = 5;
        ready_fix = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, '0);
            if (imem_req && !imem_ack && id_valid) found = 1'b1;
        end
        check("ar_reach", found, 1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_req", imem_req, 0);
        check("ar_valid", id_valid, 0);
        reset_model();
        repeat (2) step(1'b0, '0);
        rst = 1'b1;
        mem_delay = 0;
        ready_fix = 1'b1;
        step(1'b0, '0);
        check("ar_restart_req", imem_req, 1);
        check("ar_restart_addr", imem_addr, RESET_PC);
        repeat (6) step(1'b0, '0);

        // Randomized traffic: ack latency, decode readiness and redirects.
        rand_mem = 1'b1;
        ready_rand = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 15) == 0, RESET_PC + 32'(4 * $urandom_range(0, 255)));
        end
        rand_mem = 1'b0;
        ready_rand = 1'b0;
        mem_delay = 0;
        repeat (20) step(1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
